// File: rtl/keypad_pkg.sv
// Shared types, constants and key-code table for the keypad scanner.
package keypad_pkg;

   localparam int         COLS     = 4;
   localparam int         ROWS     = 4;
   localparam logic [3:0] COL_IDLE = 4'b1111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      PRESSED  = 2'd2,
      REL_DB   = 2'd3
   } kp_state_e;

   // Key index is row*4+col; the table follows the physical keypad legend.
   function automatic logic [3:0] key_code(input logic [3:0] idx);
      logic [3:0] code;
      case (idx)
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h2;
         4'd2:    code = 4'h3;
         4'd3:    code = 4'hA;
         4'd4:    code = 4'h4;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h6;
         4'd7:    code = 4'hB;
         4'd8:    code = 4'h7;
         4'd9:    code = 4'h8;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hC;
         4'd12:   code = 4'h0;
         4'd13:   code = 4'hF;
         4'd14:   code = 4'hE;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Column c is strobed by pulling bit (3-c) low.
   function automatic logic [3:0] col_drive(input logic [1:0] c);
      return ~(4'b1000 >> c);
   endfunction

endpackage

// File: rtl/keypad_frame_eval.sv
// Reduces one full scan frame to a single-key hit and its row*4+col index.
// Frame bit c*4+r is set when row r read closed while column c was driven.
module keypad_frame_eval
   import keypad_pkg::*;
(
   input  logic [15:0] frame_i,
   output logic        hit_o,
   output logic [3:0]  index_o
);

   logic [3:0] pos;

   // Exactly one closed contact counts as a key; none or several (ghosting) do not.
   always_comb begin
      hit_o = (frame_i != 16'd0) && ((frame_i & (frame_i - 16'd1)) == 16'd0);
      pos   = 4'd0;
      for (int b = 0; b < 16; b++) begin
         if (frame_i[b]) pos = 4'(b);
      end
      index_o = {pos[1:0], pos[3:2]};
   end

endmodule

// File: rtl/keypad_scanner.sv
// Keypad column strobe, row sampling, frame debounce and key-code handshake.
//
// state    | meaning
// IDLE     | no key accepted, waiting for a single-key frame
// PRESS_DB | candidate key seen, counting identical frames
// PRESSED  | key accepted and held, no repeat codes
// REL_DB   | key-free frames seen, counting toward release
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS      = 2500,
   parameter int DEBOUNCE_FRAMES = 8
) (
   input  logic       clk,
   input  logic       resetN,
   output logic [3:0] colOut,
   input  logic [3:0] rowIn,
   output logic [3:0] keyCode,
   output logic       keyValid,
   input  logic       keyReady,
   output logic       keyHeld,
   output logic       overrun
);

   localparam int            TW        = $clog2(SCAN_TICKS);
   localparam int            DW        = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_FRAMES - 1);

   logic            run_q;
   logic [TW-1:0]   tick_q;
   logic [1:0]      col_q;
   logic [3:0]      col_out_q;
   logic [3:0]      row_s1_q, row_s2_q;
   logic [15:0]     frame_q, frame_full;
   kp_state_e       state_q, state_d;
   logic [DW-1:0]   deb_q, deb_d;
   logic [3:0]      cand_q, cand_d;
   logic [3:0]      code_q, code_d;
   logic            valid_q, valid_d;
   logic            held_q, held_d;
   logic            ovr_q, ovr_d;
   logic            dwell_end, frame_end, hit, accept, hs;
   logic [3:0]      index;

   assign dwell_end = run_q && (tick_q == TICK_LAST);
   assign frame_end = dwell_end && (col_q == 2'd3);

   // Column 3 is still being sampled at frame end, so splice its live value in.
   always_comb begin
      frame_full        = frame_q;
      frame_full[15:12] = ~row_s2_q;
   end

   keypad_frame_eval u_eval (
      .frame_i (frame_full),
      .hit_o   (hit),
      .index_o (index)
   );

   // Debounce FSM, advanced only once per completed frame.
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      cand_d  = cand_q;
      accept  = 1'b0;
      if (frame_end) begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  cand_d = index;
                  if (DEBOUNCE_FRAMES == 1) begin
                     accept  = 1'b1;
                     state_d = PRESSED;
                     deb_d   = '0;
                  end else begin
                     state_d = PRESS_DB;
                     deb_d   = DW'(1);
                  end
               end
            end
            PRESS_DB: begin
               if (hit && (index == cand_q)) begin
                  if (deb_q == DEB_LAST) begin
                     accept  = 1'b1;
                     state_d = PRESSED;
                     deb_d   = '0;
                  end else begin
                     deb_d = deb_q + DW'(1);
                  end
               end else begin
                  state_d = IDLE;
                  deb_d   = '0;
               end
            end
            PRESSED: begin
               if (!hit) begin
                  if (DEBOUNCE_FRAMES == 1) begin
                     state_d = IDLE;
                     deb_d   = '0;
                  end else begin
                     state_d = REL_DB;
                     deb_d   = DW'(1);
                  end
               end
            end
            default: begin
               if (!hit) begin
                  if (deb_q == DEB_LAST) begin
                     state_d = IDLE;
                     deb_d   = '0;
                  end else begin
                     deb_d = deb_q + DW'(1);
                  end
               end else begin
                  state_d = PRESSED;
                  deb_d   = '0;
               end
            end
         endcase
      end
   end

   // Output register: a new code is taken only if the slot is free or empties this cycle.
   always_comb begin
      hs      = valid_q && keyReady;
      valid_d = valid_q && !hs;
      code_d  = code_q;
      ovr_d   = ovr_q;
      held_d  = (state_d == PRESSED) || (state_d == REL_DB);
      if (accept) begin
         if (!valid_q || hs) begin
            code_d  = key_code(index);
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // Scan timing: the first post-reset cycle only starts the strobe so every dwell is full length.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         run_q     <= 1'b0;
         tick_q    <= '0;
         col_q     <= 2'd0;
         col_out_q <= COL_IDLE;
         frame_q   <= '0;
      end else begin
         run_q     <= 1'b1;
         col_out_q <= col_drive(dwell_end ? col_q + 2'd1 : col_q);
         if (dwell_end) begin
            tick_q                   <= '0;
            col_q                    <= col_q + 2'd1;
            frame_q[{col_q, 2'b00} +: 4] <= ~row_s2_q;
         end else if (run_q) begin
            tick_q <= tick_q + TW'(1);
         end
      end
   end

   // Row synchronizer and control/handshake state.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         row_s1_q <= 4'b1111;
         row_s2_q <= 4'b1111;
         state_q  <= IDLE;
         deb_q    <= '0;
         cand_q   <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         held_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         row_s1_q <= rowIn;
         row_s2_q <= row_s1_q;
         state_q  <= state_d;
         deb_q    <= deb_d;
         cand_q   <= cand_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         held_q   <= held_d;
         ovr_q    <= ovr_d;
      end
   end

   assign colOut   = col_out_q;
   assign keyCode  = code_q;
   assign keyValid = valid_q;
   assign keyHeld  = held_q;
   assign overrun  = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 keypad model (SCAN_TICKS=4, DEBOUNCE_FRAMES=2).
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic [3:0] colOut;
   logic [3:0] rowIn;
   logic [3:0] keyCode;
   logic       keyValid;
   logic       keyReady = 1'b0;
   logic       keyHeld;
   logic       overrun;

   logic [15:0] keys = 16'd0;
   int          total = 0;
   int          bad = 0;
   int          hs_cnt = 0;
   logic [3:0]  last_code = 4'd0;
   int          h0;
   logic        found;
   logic [3:0]  exp_col;

   keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_FRAMES(2)) dut (
      .clk      (clk),
      .resetN   (resetN),
      .colOut   (colOut),
      .rowIn    (rowIn),
      .keyCode  (keyCode),
      .keyValid (keyValid),
      .keyReady (keyReady),
      .keyHeld  (keyHeld),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   // Closed key (row r, col c) pulls row r low while column c is strobed.
   always_comb begin
      rowIn = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !colOut[3-c]) rowIn[r] = 1'b0;
   end

   // Record every completed handshake.
   always @(posedge clk) begin
      if (resetN && keyValid && keyReady) begin
         hs_cnt    <= hs_cnt + 1;
         last_code <= keyCode;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stop just after the edge that starts a new frame (strobe returns to column 0).
   task automatic align(output logic ok);
      logic [3:0] prev;
      prev = colOut;
      ok   = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         step(1);
         if (colOut == 4'b0111 && prev != 4'b0111) ok = 1'b1;
         prev = colOut;
      end
   endtask

   initial begin
      // 1: reset values and column rotation
      step(3);
      chk("rst_col", colOut, 4'b1111);
      chk("rst_valid", keyValid, 1'b0);
      chk("rst_code", keyCode, 4'h0);
      chk("rst_held", keyHeld, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      resetN = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step(1);
         exp_col = 4'b1111;
         exp_col[3 - (((i - 1) / 4) % 4)] = 1'b0;
         chk($sformatf("rot_%0d", i), colOut, exp_col);
      end
      chk("rot_valid", keyValid, 1'b0);
      chk("rot_held", keyHeld, 1'b0);

      // 2: single press of '6' with consumer ready
      keyReady = 1'b1;
      h0 = hs_cnt;
      keys[6] = 1'b1;
      step(96);
      chk("k6_count", hs_cnt - h0, 1);
      chk("k6_code", last_code, 4'h6);
      chk("k6_held", keyHeld, 1'b1);
      chk("k6_valid", keyValid, 1'b0);
      keys = 16'd0;
      step(1);
      chk("k6_rel_held_a", keyHeld, 1'b1);
      step(14);
      chk("k6_rel_held_b", keyHeld, 1'b1);
      step(49);
      chk("k6_rel_held_c", keyHeld, 1'b0);
      chk("k6_rel_count", hs_cnt - h0, 1);

      // 3: bouncing 'F' rejected, then accepted once stable
      h0 = hs_cnt;
      for (int i = 0; i < 5; i++) begin
         keys[13] = 1'b1;
         step(16);
         keys[13] = 1'b0;
         step(16);
      end
      chk("bnc_count", hs_cnt - h0, 0);
      chk("bnc_held", keyHeld, 1'b0);
      keys[13] = 1'b1;
      step(15);
      chk("bnc_early", hs_cnt - h0, 0);
      step(49);
      chk("bnc_count2", hs_cnt - h0, 1);
      chk("bnc_code", last_code, 4'hF);
      chk("bnc_held2", keyHeld, 1'b1);
      keys = 16'd0;
      step(64);

      // 4: overrun while a code is pending
      keyReady = 1'b0;
      h0 = hs_cnt;
      keys[5] = 1'b1;
      step(64);
      chk("ov_valid", keyValid, 1'b1);
      chk("ov_code", keyCode, 4'h5);
      chk("ov_flag0", overrun, 1'b0);
      keys = 16'd0;
      step(64);
      chk("ov_rel_held", keyHeld, 1'b0);
      keys[3] = 1'b1;
      step(64);
      chk("ov_held", keyHeld, 1'b1);
      chk("ov_valid2", keyValid, 1'b1);
      chk("ov_code2", keyCode, 4'h5);
      chk("ov_flag1", overrun, 1'b1);
      keyReady = 1'b1;
      step(1);
      chk("ov_drop", keyValid, 1'b0);
      chk("ov_sticky", overrun, 1'b1);
      chk("ov_hs", hs_cnt - h0, 1);
      chk("ov_hs_code", last_code, 4'h5);
      keys = 16'd0;
      step(64);

      // 5: two keys rejected, remaining key accepted
      h0 = hs_cnt;
      keys[0]  = 1'b1;
      keys[10] = 1'b1;
      step(64);
      chk("mk_count", hs_cnt - h0, 0);
      chk("mk_held", keyHeld, 1'b0);
      chk("mk_valid", keyValid, 1'b0);
      keys[10] = 1'b0;
      step(64);
      chk("mk_count2", hs_cnt - h0, 1);
      chk("mk_code", last_code, 4'h1);
      chk("mk_held2", keyHeld, 1'b1);
      keys = 16'd0;
      step(64);

      // 6: reset during PRESS_DB with a code pending, then re-debounce
      keyReady = 1'b0;
      keys[0] = 1'b1;
      step(64);
      chk("rs_valid", keyValid, 1'b1);
      chk("rs_code", keyCode, 4'h1);
      keys = 16'd0;
      step(64);
      align(found);
      chk("rs_align", found, 1'b1);
      keys[6] = 1'b1;
      step(20);
      chk("rs_pre_valid", keyValid, 1'b1);
      chk("rs_pre_held", keyHeld, 1'b0);
      chk("rs_pre_ovr", overrun, 1'b1);
      resetN = 1'b0;
      step(1);
      chk("rs_col", colOut, 4'b1111);
      chk("rs_valid0", keyValid, 1'b0);
      chk("rs_code0", keyCode, 4'h0);
      chk("rs_held0", keyHeld, 1'b0);
      chk("rs_ovr0", overrun, 1'b0);
      step(1);
      resetN = 1'b1;
      keyReady = 1'b1;
      h0 = hs_cnt;
      step(80);
      chk("rs_count", hs_cnt - h0, 1);
      chk("rs_code6", last_code, 4'h6);
      chk("rs_held", keyHeld, 1'b1);
      step(32);
      chk("rs_count2", hs_cnt - h0, 1);
      keys = 16'd0;
      step(64);
      chk("rs_rel_held", keyHeld, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
